// File: rtl/vid_capture_pkg.sv
// Shared types and helpers for the vid_capture frame grabber.
// VID_CAPTURE_GREY_EN selects 8-bit luma storage instead of RGB565.
package vid_capture_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_HSTART = 4'd2;
  localparam logic [3:0] REG_HSTOP  = 4'd3;
  localparam logic [3:0] REG_VSTART = 4'd4;
  localparam logic [3:0] REG_VSTOP  = 4'd5;
  localparam logic [3:0] REG_HDIV   = 4'd6;
  localparam logic [3:0] REG_WCOUNT = 4'd7;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CONT   = 2;
  localparam int STAT_DONE   = 0;
  localparam int STAT_OVF    = 1;

`ifdef VID_CAPTURE_GREY_EN
  localparam int PIX_W = 8;
`else
  localparam int PIX_W = 16;
`endif
  localparam int PIX_PER_WORD = 64 / PIX_W;

  typedef struct packed {
    logic        en;
    logic [7:0]  we;
    logic [18:0] addr;
    logic [63:0] wrdata;
  } hid_req_t;

  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [15:0] y;
    y = 16'd77 * 16'(r) + 16'd150 * 16'(g) + 16'd29 * 16'(b);
    return y[15:8];
  endfunction

  function automatic logic [PIX_W-1:0] pix_conv(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
`ifdef VID_CAPTURE_GREY_EN
    return luma(r, g, b);
`else
    return rgb565(r, g, b);
`endif
  endfunction

endpackage

// File: rtl/vid_capture_packer.sv
// Packs converted pixels into 64-bit words, first pixel in the low lane.
// A flush emits a partial word zero-padded; clear drops anything pending.
module vid_capture_packer
  import vid_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix,
  input  logic             pix_vld,
  input  logic             flush,
  input  logic             clear,
  output logic [63:0]      word,
  output logic             word_vld
);
  localparam int LW = $clog2(PIX_PER_WORD);

  logic [LW-1:0]                        lane;
  logic [PIX_PER_WORD-1:0][PIX_W-1:0]   acc, acc_nxt;
  logic                                 last;

  assign last = (lane == LW'(PIX_PER_WORD - 1));

  for (genvar l = 0; l < PIX_PER_WORD; l++) begin : g_lane
    assign acc_nxt[l] = (pix_vld && lane == LW'(l)) ? pix : acc[l];
  end

  // acc is cleared after every emitted word, so a flush pads with zeros for free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      acc      <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        lane <= '0;
        acc  <= '0;
      end else if (pix_vld) begin
        if (last) begin
          word     <= acc_nxt;
          word_vld <= 1'b1;
          acc      <= '0;
          lane     <= '0;
        end else begin
          acc  <= acc_nxt;
          lane <= lane + LW'(1);
        end
      end else if (flush && lane != '0) begin
        word     <= acc;
        word_vld <= 1'b1;
        acc      <= '0;
        lane     <= '0;
      end
    end
  end

endmodule

// File: rtl/vid_capture.sv
// Frame grabber: windows/decimates a pixel stream into a capture RAM read over hid_*.
// Build option VID_CAPTURE_GREY_EN stores luma (8 px/word) instead of RGB565.
module vid_capture
  import vid_capture_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int CNTW  = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  vid_red,
  input  logic [7:0]  vid_green,
  input  logic [7:0]  vid_blue,
  input  logic        vid_de,
  input  logic        vid_hsyn,
  input  logic        vid_vsyn,
  input  logic        hid_en,
  input  logic [7:0]  hid_we,
  input  logic [18:0] hid_addr,
  input  logic [63:0] hid_wrdata,
  output logic [63:0] hid_rddata,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] WFULL = (AW+1)'(DEPTH);

  hid_req_t req;
  logic     wr, rd, is_reg, reg_wr, ctrl_wr, stat_wr, abort;
  logic [3:0]    ridx;
  logic [AW-1:0] ram_idx;

  assign req     = '{en: hid_en, we: hid_we, addr: hid_addr, wrdata: hid_wrdata};
  assign wr      = req.en & (|req.we);
  assign rd      = req.en & ~(|req.we);
  assign is_reg  = req.addr[14];
  assign ridx    = req.addr[6:3];
  assign ram_idx = req.addr[3 +: AW];
  assign reg_wr  = wr & is_reg;
  assign ctrl_wr = reg_wr & (ridx == REG_CTRL);
  assign stat_wr = reg_wr & (ridx == REG_STATUS);
  assign abort   = ctrl_wr & ~req.wrdata[CTRL_ARM];

  state_t          state;
  logic            arm, irq_en, cont, frame_done, ovf;
  logic [CNTW-1:0] hstart, hstop, vstart, vstop, hcnt, vcnt;
  logic [3:0]      hdiv, dcnt;
  logic [AW:0]     wptr, wcount, wptr_inc;
  logic            hsyn_q, vsyn_q, hs_edge, vs_edge;
  logic            in_win, accept, start_cap, flush, done_set;
  logic [PIX_W-1:0] pix;
  logic [63:0]     word;
  logic            word_vld, wr_en, ovf_set;

  assign hs_edge   = vid_hsyn & ~hsyn_q;
  assign vs_edge   = vid_vsyn & ~vsyn_q;
  assign start_cap = vs_edge & ~abort & ((state == ARMED) | ((state == DONE) & cont));
  assign flush     = vs_edge & (state == CAPTURE);
  assign done_set  = (state == FLUSH) & ~abort;
  assign in_win    = vid_de & ~vs_edge & (state == CAPTURE) &
                     (hcnt >= hstart) & (hcnt < hstop) & (vcnt >= vstart) & (vcnt < vstop);
  assign accept    = in_win & (dcnt == 4'd0);
  assign wr_en     = word_vld & (wptr != WFULL);
  assign ovf_set   = word_vld & (wptr == WFULL);
  assign wptr_inc  = wptr + (AW+1)'(wr_en);
  assign pix       = pix_conv(vid_red, vid_green, vid_blue);
  assign irq_o     = frame_done & irq_en;

  // Line/frame position tracking; vsyn edge takes priority over hsyn edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsyn_q <= 1'b0;
      vsyn_q <= 1'b0;
      hcnt   <= '0;
      vcnt   <= '0;
      dcnt   <= '0;
    end else begin
      hsyn_q <= vid_hsyn;
      vsyn_q <= vid_vsyn;
      if (vs_edge) begin
        hcnt <= '0;
        vcnt <= '0;
        dcnt <= '0;
      end else if (hs_edge) begin
        hcnt <= '0;
        vcnt <= vcnt + CNTW'(1);
        dcnt <= '0;
      end else if (vid_de) begin
        hcnt <= hcnt + CNTW'(1);
        if (in_win) dcnt <= (dcnt == hdiv) ? 4'd0 : dcnt + 4'd1;
      end
    end
  end

  vid_capture_packer u_packer (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .pix      (pix),
    .pix_vld  (accept),
    .flush    (flush),
    .clear    (start_cap | abort),
    .word     (word),
    .word_vld (word_vld)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      arm        <= 1'b0;
      irq_en     <= 1'b0;
      cont       <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      hstart     <= '0;
      hstop      <= CNTW'(1024);
      vstart     <= '0;
      vstop      <= CNTW'(768);
      hdiv       <= '0;
      wptr       <= '0;
      wcount     <= '0;
    end else begin
      if (ctrl_wr) begin
        arm    <= req.wrdata[CTRL_ARM];
        irq_en <= req.wrdata[CTRL_IRQ_EN];
        cont   <= req.wrdata[CTRL_CONT];
      end else if (state != IDLE) begin
        arm <= 1'b0;
      end

      // hardware set beats a same-cycle W1C
      frame_done <= (frame_done & ~(stat_wr & req.wrdata[STAT_DONE])) | done_set;
      ovf        <= (ovf & ~(stat_wr & req.wrdata[STAT_OVF])) | ovf_set;

      if (reg_wr) begin
        case (ridx)
          REG_HSTART: hstart <= req.wrdata[CNTW-1:0];
          REG_HSTOP:  hstop  <= req.wrdata[CNTW-1:0];
          REG_VSTART: vstart <= req.wrdata[CNTW-1:0];
          REG_VSTOP:  vstop  <= req.wrdata[CNTW-1:0];
          REG_HDIV:   hdiv   <= req.wrdata[3:0];
          default: ;
        endcase
      end

      if (start_cap | abort) wptr <= '0;
      else                   wptr <= wptr_inc;
      if (done_set) wcount <= wptr_inc;

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (arm) state <= ARMED;
          ARMED:   if (vs_edge) state <= CAPTURE;
          CAPTURE: if (vs_edge) state <= FLUSH;
          FLUSH:   state <= DONE;
          DONE:    if (vs_edge & cont) state <= CAPTURE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [63:0] reg_rd, reg_q, ram_q;
  logic        sel_ram;
  logic [63:0] mem [DEPTH];

  always_comb begin
    reg_rd = '0;
    case (ridx)
      REG_CTRL:   reg_rd = {61'd0, cont, irq_en, arm};
      REG_STATUS: reg_rd = {57'd0, state, 2'b00, ovf, frame_done};
      REG_HSTART: reg_rd = {{(64-CNTW){1'b0}}, hstart};
      REG_HSTOP:  reg_rd = {{(64-CNTW){1'b0}}, hstop};
      REG_VSTART: reg_rd = {{(64-CNTW){1'b0}}, vstart};
      REG_VSTOP:  reg_rd = {{(64-CNTW){1'b0}}, vstop};
      REG_HDIV:   reg_rd = {60'd0, hdiv};
      REG_WCOUNT: reg_rd = {{(63-AW){1'b0}}, wcount};
      default:    reg_rd = '0;
    endcase
  end

  // Read data is the registered select of two registered sources, so reset yields 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_ram <= 1'b0;
      reg_q   <= '0;
    end else if (rd) begin
      sel_ram <= ~is_reg;
      if (is_reg) reg_q <= reg_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr[AW-1:0]] <= word;
    if (rd & ~is_reg) ram_q <= mem[ram_idx];
  end

  assign hid_rddata = sel_ram ? ram_q : reg_q;

  logic unused_bits;
  assign unused_bits = ^{req.addr, req.wrdata};

endmodule

// File: tb/tb_vid_capture.sv
// Self-checking bench for vid_capture: register table, scoreboarded capture frames,
// decimation, padding, overflow/W1C/irq and continuous-mode abort sequences.
module tb_vid_capture;
  import vid_capture_pkg::*;

  localparam int DEPTH = 4;
`ifdef VID_CAPTURE_GREY_EN
  localparam int TPW = 8;
`else
  localparam int TPW = 16;
`endif
  localparam int TPPW = 64 / TPW;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic [7:0]  vid_red = '0, vid_green = '0, vid_blue = '0;
  logic        vid_de = 1'b0, vid_hsyn = 1'b0, vid_vsyn = 1'b0;
  logic        hid_en = 1'b0;
  logic [7:0]  hid_we = '0;
  logic [18:0] hid_addr = '0;
  logic [63:0] hid_wrdata = '0;
  logic [63:0] hid_rddata;
  logic        irq_o;

  vid_capture #(.DEPTH(DEPTH), .CNTW(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .vid_red(vid_red), .vid_green(vid_green), .vid_blue(vid_blue),
    .vid_de(vid_de), .vid_hsyn(vid_hsyn), .vid_vsyn(vid_vsyn),
    .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr), .hid_wrdata(hid_wrdata),
    .hid_rddata(hid_rddata), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_total = 0;
  logic [63:0] exp_q[$];
  int hs_c = 0, he_c = 1024, vs_c = 0, ve_c = 768, hd_c = 0;

  typedef struct {
    logic [3:0]  r;
    logic [63:0] exp;
  } rvec_t;
  rvec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [63:0] d);
    logic [18:0] a;
    a = '0; a[14] = 1'b1; a[6:3] = r;
    hid_en = 1'b1; hid_we = 8'hFF; hid_addr = a; hid_wrdata = d;
    tick();
    hid_en = 1'b0; hid_we = '0;
  endtask

  task automatic rd(input logic [18:0] a, output logic [63:0] d);
    hid_en = 1'b1; hid_we = '0; hid_addr = a;
    tick();
    hid_en = 1'b0;
    d = hid_rddata;
  endtask

  task automatic rreg(input logic [3:0] r, output logic [63:0] d);
    logic [18:0] a;
    a = '0; a[14] = 1'b1; a[6:3] = r;
    rd(a, d);
  endtask

  task automatic rram(input int i, output logic [63:0] d);
    logic [18:0] a;
    a = '0; a[13:3] = 11'(i);
    rd(a, d);
  endtask

  task automatic set_win(input int hs, input int he, input int vs, input int ve, input int hd);
    wr(REG_HSTART, 64'(hs)); wr(REG_HSTOP, 64'(he));
    wr(REG_VSTART, 64'(vs)); wr(REG_VSTOP, 64'(ve));
    wr(REG_HDIV, 64'(hd));
    hs_c = hs; he_c = he; vs_c = vs; ve_c = ve; hd_c = hd;
  endtask

  task automatic vsync();
    vid_vsyn = 1'b1; tick(); vid_vsyn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic hsync();
    vid_hsyn = 1'b1; tick(); vid_hsyn = 1'b0;
    repeat (2) tick();
  endtask

  function automatic logic [63:0] pconv(input logic [7:0] v);
`ifdef VID_CAPTURE_GREY_EN
    int y;
    y = (77 * int'(v) + 150 * int'(v) + 29 * int'(v)) >> 8;
    return 64'(y & 255);
`else
    return 64'({v[7:3], v[7:2], v[7:3]});
`endif
  endfunction

  // Drives one frame body (no vsyn) and, if push is set, queues the words the RAM should hold.
  task automatic send_frame(input int nl, input int ppl, input int base, input bit push,
                            output int nwords);
    logic [63:0] w;
    logic [7:0]  val;
    int lane, k;
    w = '0; lane = 0; nwords = 0;
    for (int v = 0; v < nl; v++) begin
      if (v > 0) hsync();
      k = 0;
      for (int h = 0; h < ppl; h++) begin
        val = 8'((base + v * ppl + h) * 17);
        vid_de = 1'b1; vid_red = val; vid_green = val; vid_blue = val;
        tick();
        if (v >= vs_c && v < ve_c && h >= hs_c && h < he_c) begin
          if (k % (hd_c + 1) == 0) begin
            w = w | (pconv(val) << (lane * TPW));
            lane++;
            if (lane == TPPW) begin
              if (push && nwords < DEPTH) exp_q.push_back(w);
              nwords++; w = '0; lane = 0;
            end
          end
          k++;
        end
      end
      vid_de = 1'b0;
      repeat (2) tick();
    end
    if (lane != 0) begin
      if (push && nwords < DEPTH) exp_q.push_back(w);
      nwords++;
    end
  endtask

  task automatic check_words(input string name, input int n);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      rram(i, d);
      if (exp_q.size() == 0) check({name, "_q_empty"}, d, 64'hDEAD_0000_0000_DEAD);
      else check(name, d, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [63:0] d, last_w;
    int nw;

    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check("rddata_reset", hid_rddata, 64'd0);
    check("irq_reset", 64'(irq_o), 64'd0);

    tbl[0] = '{REG_CTRL,   64'd0};
    tbl[1] = '{REG_STATUS, 64'd0};
    tbl[2] = '{REG_HSTART, 64'd0};
    tbl[3] = '{REG_HSTOP,  64'd1024};
    tbl[4] = '{REG_VSTART, 64'd0};
    tbl[5] = '{REG_VSTOP,  64'd768};
    tbl[6] = '{REG_HDIV,   64'd0};
    tbl[7] = '{REG_WCOUNT, 64'd0};
    tbl[8] = '{4'd9,       64'd0};
    for (int i = 0; i < 9; i++) begin
      rreg(tbl[i].r, d);
      check($sformatf("reset_reg%0d", tbl[i].r), d, tbl[i].exp);
    end

    // ramp: 8x2 window, two lines of 10 pixels
    set_win(0, 8, 0, 2, 0);
    wr(REG_CTRL, 64'h1);
    tick();
    rreg(REG_STATUS, d); check("armed_state", 64'(d[6:4]), 64'(ARMED));
    vsync();
    rreg(REG_STATUS, d); check("capture_state", 64'(d[6:4]), 64'(CAPTURE));
    send_frame(2, 10, 0, 1'b1, nw);
    vsync();
    rreg(REG_STATUS, d);
    check("ramp_status", 64'(d[1:0]), 64'd1);
    check("ramp_done_state", 64'(d[6:4]), 64'(DONE));
    check("ramp_irq_masked", 64'(irq_o), 64'd0);
    rreg(REG_WCOUNT, d); check("ramp_wcount", d, 64'(nw));
`ifndef VID_CAPTURE_GREY_EN
    check("ramp_nwords", 64'(nw), 64'd4);
    rram(0, d); check("ramp_word0_const", d, 64'h3186_2104_1082_0000);
`endif
    check_words("ramp_word", nw);
    wr(REG_STATUS, 64'h3);
    wr(REG_CTRL, 64'h0);

    // decimation: take 1, skip 1
    set_win(0, 8, 0, 1, 1);
    wr(REG_CTRL, 64'h1);
    tick();
    vsync();
    send_frame(2, 8, 3, 1'b1, nw);
    vsync();
    rreg(REG_WCOUNT, d); check("hdiv_wcount", d, 64'd1);
    check_words("hdiv_word", nw);
    wr(REG_STATUS, 64'h3);
    wr(REG_CTRL, 64'h0);

    // width 6: partial last word must be zero padded
    set_win(0, 6, 0, 1, 0);
    wr(REG_CTRL, 64'h1);
    tick();
    vsync();
    send_frame(1, 8, 5, 1'b1, nw);
    vsync();
    rreg(REG_WCOUNT, d); check("pad_wcount", d, 64'(nw));
`ifndef VID_CAPTURE_GREY_EN
    check("pad_nwords", 64'(nw), 64'd2);
    rram(1, d); check("pad_word1_upper", 64'(d[63:32]), 64'd0);
`endif
    check_words("pad_word", nw);
    wr(REG_STATUS, 64'h3);
    wr(REG_CTRL, 64'h0);

    // overflow: 64 pixels into a 4-word RAM, irq enabled
    set_win(0, 64, 0, 1, 0);
    wr(REG_CTRL, 64'h3);
    tick();
    vsync();
    send_frame(1, 64, 9, 1'b1, nw);
    vsync();
    rreg(REG_STATUS, d); check("ovf_status", 64'(d[1:0]), 64'd3);
    rreg(REG_WCOUNT, d); check("ovf_wcount", d, 64'(DEPTH));
    check("ovf_irq", 64'(irq_o), 64'd1);
    check_words("ovf_word", DEPTH);
    wr(REG_STATUS, 64'h3);
    rreg(REG_STATUS, d); check("w1c_status", 64'(d[1:0]), 64'd0);
    check("w1c_irq", 64'(irq_o), 64'd0);
    wr(REG_CTRL, 64'h0);

    // continuous mode, then abort in the middle of the third frame
    set_win(0, 8, 0, 1, 0);
    wr(REG_CTRL, 64'h5);
    tick();
    vsync();
    send_frame(1, 8, 100, 1'b1, nw);
    vsync();
    rreg(REG_STATUS, d); check("cont_f1_state", 64'(d[6:4]), 64'(DONE));
    check_words("cont_f1_word", nw);
    send_frame(1, 8, 50, 1'b0, nw);
    vsync();
    rreg(REG_STATUS, d); check("cont_rearm_state", 64'(d[6:4]), 64'(CAPTURE));
    send_frame(1, 8, 200, 1'b1, nw);
    vsync();
    rreg(REG_WCOUNT, d); check("cont_f2_wcount", d, 64'(nw));
    last_w = exp_q[exp_q.size() - 1];
    check_words("cont_f2_word", nw);
    vsync();
    for (int h = 0; h < 4; h++) begin
      vid_de = 1'b1; vid_red = 8'(h * 31 + 7); vid_green = 8'hAA; vid_blue = 8'h55;
      tick();
    end
    vid_de = 1'b0;
    repeat (2) tick();
    wr(REG_CTRL, 64'h0);
    rreg(REG_STATUS, d); check("abort_idle", 64'(d[6:4]), 64'(IDLE));
    for (int h = 0; h < 4; h++) begin
      vid_de = 1'b1; vid_red = 8'hF0; vid_green = 8'h0F; vid_blue = 8'h3C;
      tick();
    end
    vid_de = 1'b0;
    vsync();
    rram(nw - 1, d); check("abort_no_write", d, last_w);
    rreg(REG_WCOUNT, d); check("abort_wcount", d, 64'(nw));
    rreg(REG_STATUS, d); check("abort_stays_idle", 64'(d[6:4]), 64'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
